accel_spi_responder: RTL

ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

---
 rtl/accel_spi_responder_if.sv | 19 +
 rtl/accel_spi_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_spi_responder_if.sv
// 3-wire SPI pins between an initiator and the accelerometer responder.
// The responder only produces drive value and enable; the tristate lives above.
interface accel_spi_responder_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_sdat_i;
  logic spi_sdat_o;
  logic spi_sdat_oe;

  modport master (
    output spi_sclk, spi_cs_n, spi_sdat_i,
    input  spi_sdat_o, spi_sdat_oe
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_sdat_i,
    output spi_sdat_o, spi_sdat_oe
  );
endinterface

// File: rtl/accel_spi_responder.sv
// Mode-3, 3-wire SPI register responder for an accelerometer-style device
// with a double-buffered XYZ sample and a data-ready interrupt.
module accel_spi_responder (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  accel_spi_responder_if.slave  spi,
  output logic                  g_sensor_int,
  input  logic [15:0]           sample_x,
  input  logic [15:0]           sample_y,
  input  logic [15:0]           sample_z,
  input  logic                  sample_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_DATA
  } state_e;

  logic [1:0] sclk_q, cs_q, sdat_q, flush_q;
  logic       sclk_prev_q, cs_prev_q, armed_q;
  logic       sclk_s, cs_s, sdat_s;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_q[1];
  assign cs_s      = cs_q[1];
  assign sdat_s    = sdat_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // armed_q stays low until a real high cs_n is seen after reset,
  // so a frame cut by reset is ignored to its end.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sclk_q      <= 2'b11;
      cs_q        <= 2'b11;
      sdat_q      <= 2'b00;
      flush_q     <= 2'b00;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[0], spi.spi_sclk};
      cs_q        <= {cs_q[0], spi.spi_cs_n};
      sdat_q      <= {sdat_q[0], spi.spi_sdat_i};
      flush_q     <= {flush_q[0], 1'b1};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      armed_q     <= armed_q | (flush_q[1] & cs_s);
    end
  end

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d;
  logic [5:0] addr_q, addr_d;
  logic       mb_q, mb_d;
  logic       oe_q, oe_d;
  logic       sdo_q, sdo_d;
  logic       rd_done_q, rd_done_d;

  logic [7:0]  bw_q, bw_d, pwr_q, pwr_d;
  logic [7:0]  ien_q, ien_d, fmt_q, fmt_d;
  logic [47:0] data_q, data_d, pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic        drdy_q, drdy_d;
  logic        int_q, int_d;

  logic [7:0] rd_byte, rx_next;
  logic       we, in_data_rng;
  logic       take, apply, clr;

  assign rx_next     = {rx_q[6:0], sdat_s};
  assign in_data_rng = (addr_q >= 6'h32) && (addr_q <= 6'h37);

  always_comb begin
    rd_byte = 8'h00;
    case (addr_q)
      6'h00:   rd_byte = 8'hE5;
      6'h2C:   rd_byte = bw_q;
      6'h2D:   rd_byte = pwr_q;
      6'h2E:   rd_byte = ien_q;
      6'h30:   rd_byte = {drdy_q, 7'b0};
      6'h31:   rd_byte = fmt_q;
      6'h32:   rd_byte = data_q[7:0];
      6'h33:   rd_byte = data_q[15:8];
      6'h34:   rd_byte = data_q[23:16];
      6'h35:   rd_byte = data_q[31:24];
      6'h36:   rd_byte = data_q[39:32];
      6'h37:   rd_byte = data_q[47:40];
      default: rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    mb_d      = mb_q;
    oe_d      = oe_q;
    sdo_d     = sdo_q;
    rd_done_d = rd_done_q;
    we        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d   = CMD;
          cnt_d     = 3'd0;
          rd_done_d = 1'b0;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          rx_d  = rx_next;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            mb_d    = rx_next[6];
            addr_d  = rx_next[5:0];
            state_d = rx_next[7] ? RD_DATA : WR_DATA;
          end
        end
      end
      WR_DATA: begin
        if (sclk_rise) begin
          rx_d  = rx_next;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            we = 1'b1;
            if (mb_q) addr_d = addr_q + 6'd1;
          end
        end
      end
      RD_DATA: begin
        // a falling edge at bit 0 starts a fresh byte from the current address
        if (sclk_fall) begin
          oe_d = 1'b1;
          if (cnt_q == 3'd0) begin
            sdo_d = rd_byte[7];
            tx_d  = {rd_byte[6:0], 1'b0};
          end else begin
            sdo_d = tx_q[7];
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end
        if (sclk_rise) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (in_data_rng) rd_done_d = 1'b1;
            if (mb_q) addr_d = addr_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && cs_rise) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      sdo_d   = 1'b0;
      we      = 1'b0;
    end
  end

  always_comb begin
    bw_d   = bw_q;
    pwr_d  = pwr_q;
    ien_d  = ien_q;
    fmt_d  = fmt_q;
    data_d = data_q;
    pend_d = pend_q;
    take   = sample_valid & pwr_q[3];
    apply  = (state_q == IDLE) & pend_v_q;
    // unapplied new data keeps DATA_READY alive past a data read
    clr    = cs_rise & (state_q == RD_DATA) & rd_done_q & ~pend_v_q;
    if (we) begin
      case (addr_q)
        6'h2C:   bw_d  = rx_next;
        6'h2D:   pwr_d = rx_next;
        6'h2E:   ien_d = rx_next;
        6'h31:   fmt_d = rx_next;
        default: ;
      endcase
    end
    if (apply) data_d = pend_q;
    if (take) pend_d = {sample_z, sample_y, sample_x};
    pend_v_d = take | (pend_v_q & ~apply);
    drdy_d   = take | (drdy_q & ~clr);
    int_d    = drdy_q & ien_q[7];
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      rx_q      <= 8'h00;
      tx_q      <= 8'h00;
      addr_q    <= 6'h00;
      mb_q      <= 1'b0;
      oe_q      <= 1'b0;
      sdo_q     <= 1'b0;
      rd_done_q <= 1'b0;
      bw_q      <= 8'h0A;
      pwr_q     <= 8'h00;
      ien_q     <= 8'h00;
      fmt_q     <= 8'h00;
      data_q    <= 48'h0;
      pend_q    <= 48'h0;
      pend_v_q  <= 1'b0;
      drdy_q    <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      mb_q      <= mb_d;
      oe_q      <= oe_d;
      sdo_q     <= sdo_d;
      rd_done_q <= rd_done_d;
      bw_q      <= bw_d;
      pwr_q     <= pwr_d;
      ien_q     <= ien_d;
      fmt_q     <= fmt_d;
      data_q    <= data_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      drdy_q    <= drdy_d;
      int_q     <= int_d;
    end
  end

  // enable is masked by synced cs_n so it drops before the FSM unwinds
  assign spi.spi_sdat_oe = oe_q & ~cs_s;
  assign spi.spi_sdat_o  = sdo_q;
  assign g_sensor_int    = int_q;
  assign busy            = (state_q != IDLE);

endmodule
